// File: rtl/kgp_risc_pkg.sv
// Shared KGP-RISC definitions: arbiter state encoding and datapath width.
package kgp_risc_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/adder.sv
// Shared ripple-style adder: {cout, sum} = a + b + cin, modulo 2^WIDTH.
module Adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid request at or above rr_ptr, wrapping.
module rr_picker #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  int unsigned idx;

  // Walk the requesters starting at rr_ptr; the first valid one wins.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!any && req_valid[idx]) begin
        any    = 1'b1;
        winner = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one Adder among NUM_REQ requesters.
module adder_arbiter
  import kgp_risc_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned WIDTH   = DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  input  logic [NUM_REQ-1:0]         req_cin,
  output logic [NUM_REQ-1:0]         resp_valid,
  input  logic [NUM_REQ-1:0]         resp_ready,
  output logic [WIDTH-1:0]           resp_sum,
  output logic                       resp_cout,
  output logic                       resp_ovf,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  arb_state_e       state_q, state_d;
  logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]  grant_q;
  logic [IdxW-1:0]  winner;
  logic             any;
  logic             grant_fire;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             cin_q, cout_q, ovf_q;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .winner    (winner),
    .any       (any)
  );

  // Adder only ever sees the operand registers, never the live request buses.
  Adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (a_q),
    .b    (b_q),
    .cin  (cin_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Next-state, grant and response-valid decode.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    req_ready  = '0;
    resp_valid = '0;
    grant_fire = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (any && !rst) begin
          req_ready[winner] = 1'b1;
          grant_fire        = 1'b1;
          rr_ptr_d          = (winner == IdxW'(NUM_REQ - 1)) ? '0 : winner + IdxW'(1);
          state_d           = ARB_EXEC;
        end
      end
      ARB_EXEC: state_d = ARB_RESP;
      ARB_RESP: begin
        // A reset cycle suppresses the response so a discarded op is never seen.
        if (!rst) resp_valid[grant_q] = 1'b1;
        if (resp_ready[grant_q]) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State, pointer, operand capture and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (grant_fire) begin
        grant_q <= winner;
        a_q     <= req_a[int'(winner)*WIDTH +: WIDTH];
        b_q     <= req_b[int'(winner)*WIDTH +: WIDTH];
        cin_q   <= req_cin[winner];
      end
      if (state_q == ARB_EXEC) begin
        sum_q  <= add_sum;
        cout_q <= add_cout;
        ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) & (add_sum[WIDTH-1] != a_q[WIDTH-1]);
      end
    end
  end

  assign resp_sum  = sum_q;
  assign resp_cout = cout_q;
  assign resp_ovf  = ovf_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: cycle model plus result scoreboard.
module tb_adder_arbiter;

  localparam int unsigned N = 3;
  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready, req_cin;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   resp_valid, resp_ready;
  logic [W-1:0]   resp_sum;
  logic           resp_cout, resp_ovf, busy;
  logic [1:0]     grant_id;

  always #5 clk = ~clk;

  adder_arbiter #(
    .NUM_REQ (N),
    .WIDTH   (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .resp_cout  (resp_cout),
    .resp_ovf   (resp_ovf),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   m_state = 0;  // 0 idle, 1 exec, 2 resp
  int   m_ptr = 0;
  int   m_gid = 0;
  int   cyc = 0;
  int   dut_grants[$];
  int   grant_cyc[$];

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick(logic [N-1:0] v, int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Advance the model across one rising edge, then check the DUT on the falling edge.
  task automatic tick();
    int           w;
    logic [W:0]   s;
    logic [W-1:0] a, b;
    exp_t         e;
    logic [N-1:0] er, ev;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_state = 0;
      m_ptr   = 0;
      m_gid   = 0;
      sb.delete();
    end else begin
      case (m_state)
        0: begin
          w = pick(req_valid, m_ptr);
          if (w >= 0) begin
            a      = req_a[w*W +: W];
            b      = req_b[w*W +: W];
            s      = {1'b0, a} + {1'b0, b} + (W + 1)'(req_cin[w]);
            e.id   = 2'(w);
            e.sum  = s[W-1:0];
            e.cout = s[W];
            e.ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
            sb.push_back(e);
            m_gid   = w;
            m_ptr   = (w + 1) % N;
            m_state = 1;
          end
        end
        1: m_state = 2;
        default: begin
          if (resp_ready[m_gid]) begin
            m_state = 0;
            if (sb.size() > 0) void'(sb.pop_front());
          end
        end
      endcase
    end
    @(negedge clk);
    er = '0;
    if (!rst && m_state == 0) begin
      w = pick(req_valid, m_ptr);
      if (w >= 0) er[w] = 1'b1;
    end
    check_eq("req_ready", req_ready, er);
    ev = '0;
    if (!rst && m_state == 2) ev[m_gid] = 1'b1;
    check_eq("resp_valid", resp_valid, ev);
    check_eq("busy", busy, m_state != 0);
    if (m_state != 0) check_eq("grant_id", grant_id, m_gid);
    if (!rst && m_state == 2) begin
      check_eq("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb[0];
        check_eq("resp_sum", resp_sum, e.sum);
        check_eq("resp_cout", resp_cout, e.cout);
        check_eq("resp_ovf", resp_ovf, e.ovf);
      end
    end
    // Log the DUT's own view of each new grant (exec cycle: busy, no response).
    if (!rst && busy === 1'b1 && resp_valid === '0) begin
      dut_grants.push_back(int'(grant_id));
      grant_cyc.push_back(cyc);
    end
  endtask

  task automatic do_op(int i, logic [W-1:0] a, logic [W-1:0] b, logic cin, int hold,
                       bit chk, logic [W-1:0] esum, logic ecout, logic eovf);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = cin;
    req_valid[i]    = 1'b1;
    tick();
    req_valid[i] = 1'b0;
    tick();
    if (chk) begin
      check_eq("op_sum", resp_sum, esum);
      check_eq("op_cout", resp_cout, ecout);
      check_eq("op_ovf", resp_ovf, eovf);
    end
    repeat (hold) tick();
    resp_ready[i] = 1'b1;
    tick();
    resp_ready[i] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = '1;
    req_a      = '0;
    req_b      = '0;
    req_cin    = '0;
    resp_ready = '0;

    // Reset held two cycles with every requester valid.
    repeat (2) begin
      tick();
      check_eq("rst_sum", resp_sum, 0);
      check_eq("rst_cout", resp_cout, 0);
      check_eq("rst_ovf", resp_ovf, 0);
      check_eq("rst_grant_id", grant_id, 0);
    end
    rst = 1'b0;
    #1;
    check_eq("ready_after_rst", req_ready, 3'b001);
    req_valid = '0;
    tick();

    // Single op on requester 1, response held unacknowledged for 4 cycles.
    req_a[1*W +: W] = 32'h0000_0005;
    req_b[1*W +: W] = 32'h0000_0003;
    req_cin[1]      = 1'b1;
    req_valid[1]    = 1'b1;
    tick();
    req_valid[1] = 1'b0;
    tick();
    check_eq("single_resp_valid", resp_valid, 3'b010);
    repeat (4) begin
      tick();
      check_eq("hold_sum", resp_sum, 32'd9);
      check_eq("hold_cout", resp_cout, 0);
      check_eq("hold_ovf", resp_ovf, 0);
      check_eq("hold_valid", resp_valid, 3'b010);
    end
    resp_ready = 3'b010;
    tick();
    resp_ready = '0;
    check_eq("single_done_busy", busy, 0);

    // Carry-out and signed overflow boundaries; pointer ends back at 0.
    do_op(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 0, 1'b1, 32'h0, 1'b1, 1'b0);
    do_op(2, 32'h7FFF_FFFF, 32'h1, 1'b0, 1, 1'b1, 32'h8000_0000, 1'b0, 1'b1);

    // Round robin with everyone valid and immediate acknowledge.
    dut_grants.delete();
    grant_cyc.delete();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = $urandom();
      req_b[i*W +: W] = $urandom();
      req_cin[i]      = 1'($urandom_range(0, 1));
    end
    req_valid  = '1;
    resp_ready = '1;
    repeat (18) tick();
    req_valid = '0;
    repeat (2) tick();
    resp_ready = '0;
    check_eq("rr_count", dut_grants.size(), 6);
    for (int k = 0; k < 6 && k < dut_grants.size(); k++) begin
      check_eq("rr_order", dut_grants[k], k % 3);
      if (k > 0) check_eq("rr_spacing", grant_cyc[k] - grant_cyc[k-1], 3);
    end

    // Reset while in EXEC: op is dropped, pointer returns to 0.
    req_valid = 3'b010;
    tick();
    req_valid = '0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    dut_grants.delete();
    req_valid = '1;
    tick();
    req_valid = '0;
    check_eq("midrst_grants", dut_grants.size(), 1);
    if (dut_grants.size() > 0) check_eq("midrst_first_grant", dut_grants[0], 0);
    tick();
    resp_ready = '1;
    tick();
    resp_ready = '0;

    // Stray acknowledge from another requester is ignored; others may toggle valid.
    req_valid = 3'b100;
    tick();
    req_valid = '0;
    tick();
    resp_ready = 3'b001;
    req_valid  = 3'b011;
    tick();
    req_valid = '0;
    repeat (2) tick();
    check_eq("stray_busy", busy, 1);
    check_eq("stray_valid", resp_valid, 3'b100);
    resp_ready = 3'b100;
    tick();
    resp_ready = '0;
    check_eq("stray_released", busy, 0);

    // Random single operations through the scoreboard.
    for (int n = 0; n < 8; n++) begin
      do_op($urandom_range(0, N - 1), $urandom(), $urandom(), 1'($urandom_range(0, 1)),
            $urandom_range(0, 2), 1'b0, '0, 1'b0, 1'b0);
    end
    tick();
    check_eq("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
